// File: rtl/parking_controller_multi.sv
// Gate controller for a multi-slot car park: occupancy tracking, password entry with lockout, blinking LEDs, 7-seg display.
// Optional macro PARKING_OCC_DISPLAY_EN shows the occupancy count on HEX_1/HEX_2 while idle and not full.
module parking_controller_multi #(
  parameter int              CAPACITY    = 8,
  parameter int              PW_W        = 4,
  parameter logic [PW_W-1:0] PASS_CODE   = 4'hA,
  parameter int              WAIT_CYCLES = 16,
  parameter int              MAX_TRIES   = 3,
  parameter int              LOCK_CYCLES = 32,
  parameter int              BLINK_DIV   = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            sensor_entrance,
  input  logic                            sensor_exit,
  input  logic                            car_leave,
  input  logic                            pass_valid,
  input  logic [PW_W-1:0]                 pass_code,
  output logic                            GREEN_LED,
  output logic                            RED_LED,
  output logic [6:0]                      HEX_1,
  output logic [6:0]                      HEX_2,
  output logic [$clog2(CAPACITY+1)-1:0]   occupancy,
  output logic                            full,
  output logic                            lockout
);

  localparam int OW  = $clog2(CAPACITY + 1);
  localparam int TW  = $clog2(((WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES) + 1);
  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_PASSWORD, WRONG_PASS, RIGHT_PASS, STOP, LOCKED
  } state_t;

  state_t         state, state_next;
  logic [TW-1:0]  timer;
  logic [TRW-1:0] tries, tries_next;
  logic [BW-1:0]  presc;
  logic           blink;
  logic           code_ok, inc_occ;
  logic           green_d, red_d;
  logic [6:0]     hex1_d, hex2_d;

  assign code_ok = (pass_code == PASS_CODE);
  assign full    = (occupancy == OW'(CAPACITY));
  assign lockout = (state == LOCKED);

  always_comb begin
    state_next = state;
    tries_next = tries;
    inc_occ    = 1'b0;
    case (state)
      IDLE: if (sensor_entrance && !full) state_next = WAIT_PASSWORD;
      WAIT_PASSWORD, WRONG_PASS: begin
        if (pass_valid) begin
          if (code_ok) begin
            state_next = RIGHT_PASS;
          end else begin
            tries_next = tries + 1'b1;
            state_next = (tries_next >= TRW'(MAX_TRIES)) ? LOCKED : WRONG_PASS;
          end
        end else if (state == WAIT_PASSWORD && timer == TW'(WAIT_CYCLES - 1)) begin
          state_next = IDLE;
          tries_next = '0;
        end
      end
      RIGHT_PASS: begin
        if (sensor_entrance && sensor_exit) begin
          state_next = STOP;
        end else if (sensor_exit) begin
          state_next = IDLE;
          inc_occ    = 1'b1;
        end
      end
      STOP: if (pass_valid && code_ok) state_next = RIGHT_PASS;
      LOCKED: begin
        if (timer == TW'(LOCK_CYCLES - 1)) begin
          state_next = IDLE;
          tries_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == RIGHT_PASS) tries_next = '0;
  end

  // Timer and blink prescaler restart on every state change so blinking always begins lit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tries <= '0;
      timer <= '0;
      presc <= '0;
      blink <= 1'b1;
    end else begin
      state <= state_next;
      tries <= tries_next;
      if (state_next != state) begin
        timer <= '0;
        presc <= '0;
        blink <= 1'b1;
      end else begin
        timer <= (state == WAIT_PASSWORD || state == LOCKED) ? timer + 1'b1 : '0;
        if (presc == BW'(BLINK_DIV - 1)) begin
          presc <= '0;
          blink <= ~blink;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
    end else if (inc_occ && !car_leave) begin
      if (!full) occupancy <= occupancy + 1'b1;
    end else if (car_leave && !inc_occ) begin
      if (occupancy != '0) occupancy <= occupancy - 1'b1;
    end
  end

`ifdef PARKING_OCC_DISPLAY_EN
  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: seg7 = 7'h40;
      1: seg7 = 7'h79;
      2: seg7 = 7'h24;
      3: seg7 = 7'h30;
      4: seg7 = 7'h19;
      5: seg7 = 7'h12;
      6: seg7 = 7'h02;
      7: seg7 = 7'h78;
      8: seg7 = 7'h00;
      9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  int occ_tens, occ_units;
  assign occ_tens  = (int'(occupancy) / 10) % 10;
  assign occ_units = int'(occupancy) % 10;
`endif

  always_comb begin
    green_d = 1'b0;
    red_d   = 1'b0;
    hex1_d  = 7'h7F;
    hex2_d  = 7'h7F;
    case (state)
      IDLE: begin
        if (full) begin
          hex1_d = 7'h0E;
          hex2_d = 7'h41;
        end
`ifdef PARKING_OCC_DISPLAY_EN
        else begin
          hex1_d = (occ_tens == 0) ? 7'h7F : seg7(occ_tens);
          hex2_d = seg7(occ_units);
        end
`endif
      end
      WAIT_PASSWORD: begin
        red_d  = 1'b1;
        hex1_d = 7'h06;
        hex2_d = 7'h2B;
      end
      WRONG_PASS: begin
        red_d  = blink;
        hex1_d = 7'h06;
        hex2_d = 7'h06;
      end
      RIGHT_PASS: begin
        green_d = blink;
        hex1_d  = 7'h02;
        hex2_d  = 7'h40;
      end
      STOP: begin
        red_d  = blink;
        hex1_d = 7'h12;
        hex2_d = 7'h0C;
      end
      LOCKED: begin
        red_d  = 1'b1;
        hex1_d = 7'h47;
        hex2_d = 7'h47;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
      HEX_1     <= 7'h7F;
      HEX_2     <= 7'h7F;
    end else begin
      GREEN_LED <= green_d;
      RED_LED   <= red_d;
      HEX_1     <= hex1_d;
      HEX_2     <= hex2_d;
    end
  end

endmodule
